knn_vote: RTL and testbench
===========================

Name: knn_vote

Overview:
Majority-vote classifier at the downstream end of the sorted-neighbour interface in the KNN pipeline. It reads the registered sorted distance and type arrays when valid_sort pulses, and takes the K nearest entries. It counts class votes sequentially, resolves the winner, and presents the predicted class with a one-cycle valid_class pulse. It is the consumer (reader) of the sorter's output bus.

Parameters:
N, 8, number of entries in sorted arrays
W, 16, width of each distance/type word
K, 3, neighbours voted (1 <= K <= N)
NUM_CLASSES, 4, valid class labels 0..NUM_CLASSES-1 (>= 2)

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
valid_sort  input  1  one-cycle pulse; sorted arrays valid this cycle
distance_array_sorted  input  W x [0:N-1]  ascending distances, index 0 nearest
type_array_sorted  input  W x [0:N-1]  class label paired with each distance
ready  output  1  high in IDLE; valid_sort accepted only when ready=1
class_out  output  W  predicted class (zero-extended)
vote_count  output  W  votes for the winning class
winner_distance  output  W  distance of the nearest neighbour of the winning class
valid_class  output  1  one-cycle pulse; class_out/vote_count/winner_distance update the same cycle
overrun  output  1  one-cycle pulse when valid_sort arrives with ready=0

Behaviour:
- Reset: all outputs 0 except ready=1; FSM=IDLE; counters and captured entries cleared. Reset mid-operation aborts with no valid_class. Normal acceptance resumes the cycle after rst deasserts.
- IDLE: if valid_sort, capture type[0..K-1] and distance[0..K-1]. Clear the per-class counters (width $clog2(K+1)) and first-seen ranks. Go to COUNT with index i=0.
- COUNT (K cycles): for entry i, if type < NUM_CLASSES, increment counter[type]. If this is the first occurrence of that class, record rank i and distance. Labels >= NUM_CLASSES are ignored. Leave after i=K-1.
- ARGMAX (NUM_CLASSES cycles): scan c=0..NUM_CLASSES-1. Replace the best candidate if counter[c] > best count. Equal counts use the tie-break rule (see Optional Feature). Classes with count 0 never win.
- On exit from ARGMAX, register the results and pulse valid_class. Return to IDLE on the same edge, so ready=1 in the valid_class cycle.
- Latency: valid_sort sampled at edge t gives valid_class high after edge t+1+K+NUM_CLASSES (8 cycles at defaults).
- No valid label among K entries: class_out=0, vote_count=0, winner_distance=0, valid_class still pulses.
- valid_sort while busy: ignored, overrun pulses one cycle, and the in-flight result is unaffected.
- valid_sort coincident with valid_class: accepted, because ready=1.
- class_out, vote_count and winner_distance hold their values between valid_class pulses.

Optional Feature:
- KNN_NEAREST_TIEBREAK_EN.
- Defined: on equal counts, the class whose first occurrence has the smaller rank wins, i.e. the nearer neighbour wins.
- Undefined: on equal counts, the lower class index wins; first-seen rank storage is not needed for the tie decision. winner_distance remains supported either way.

Decomposition:
- knn_pkg: FSM state enum (IDLE, COUNT, ARGMAX); localparams for counter width $clog2(K+1) and rank width $clog2(K); a shared function class_valid(label).
- One sub-module, knn_class_counters: per-class counter bank with clear/increment, plus first-seen rank/distance registers.
- The FSM and argmax scan live in knn_vote.

Test Plan:
- Defaults. Types [2,2,1,0,...], distances [3,5,9,...] -> class_out=2, vote_count=2, winner_distance=3, valid_class exactly 8 cycles after valid_sort.
- Tie. Types [1,3,0], distances [4,6,7]. Macro undefined -> class_out=0, vote_count=1, winner_distance=7. Macro defined -> class_out=1, winner_distance=4.
- Invalid labels. Types [5,5,2] -> class_out=2, vote_count=1. Types [7,7,7] -> class_out=0, vote_count=0, winner_distance=0, valid_class still pulses.
- Overrun. Second valid_sort 2 cycles after the first -> overrun=1 for one cycle, ready stays 0, result matches the first input only.
- Reset mid-COUNT. rst high 1 cycle -> all outputs 0, ready=1 next cycle, no valid_class. A new valid_sort then completes with correct class after 8 cycles.
- Back-to-back. valid_sort asserted in the valid_class cycle -> accepted. Second valid_class follows 8 cycles later with the second input's result.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared definitions for the KNN majority-vote block: controller states,
// default sizing, derived counter/rank widths and the class-label validity test.
package knn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COUNT  = 2'd1,
    ARGMAX = 2'd2
  } state_t;

  localparam int KNN_N           = 8;
  localparam int KNN_W           = 16;
  localparam int KNN_K           = 3;
  localparam int KNN_NUM_CLASSES = 4;

  // A class can collect at most K votes; a first-seen rank lies in 0..K-1.
  localparam int KNN_CNT_W  = $clog2(KNN_K + 1);
  localparam int KNN_RANK_W = (KNN_K > 1) ? $clog2(KNN_K) : 1;

  // Labels outside 0..numClasses-1 carry no vote.
  function automatic logic class_valid(input logic [63:0] label,
                                       input int unsigned numClasses);
    return label < 64'(numClasses);
  endfunction

endpackage

// File: rtl/knn_class_counters.sv
// Per-class vote counter bank. Also remembers, for each class, the distance
// of its first (nearest) occurrence and, when KNN_NEAREST_TIEBREAK_EN is
// defined, the rank at which it was first seen.
module knn_class_counters
  import knn_pkg::*;
#(
  parameter int NUM_CLASSES = KNN_NUM_CLASSES,
  parameter int W           = KNN_W,
  parameter int CNT_W       = KNN_CNT_W,
  parameter int RANK_W      = KNN_RANK_W,
  parameter int CLS_W       = $clog2(NUM_CLASSES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic [CLS_W-1:0]  class_i,
  input  logic [W-1:0]      dist_i,
`ifdef KNN_NEAREST_TIEBREAK_EN
  input  logic [RANK_W-1:0] rank_i,
  output logic [RANK_W-1:0] rank_o [NUM_CLASSES],
`endif
  output logic [CNT_W-1:0]  count_o [NUM_CLASSES],
  output logic [W-1:0]      dist_o  [NUM_CLASSES]
);

  logic [CNT_W-1:0] count_q [NUM_CLASSES];
  logic [W-1:0]     dist_q  [NUM_CLASSES];
`ifdef KNN_NEAREST_TIEBREAK_EN
  logic [RANK_W-1:0] rank_q [NUM_CLASSES];
`endif

  // Clear the whole bank at the start of a vote; otherwise bump the selected
  // class and latch its distance (and rank) only on its first occurrence.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      for (int c = 0; c < NUM_CLASSES; c++) begin
        count_q[c] <= '0;
        dist_q[c]  <= '0;
`ifdef KNN_NEAREST_TIEBREAK_EN
        rank_q[c]  <= '0;
`endif
      end
    end else if (inc_i) begin
      count_q[class_i] <= count_q[class_i] + CNT_W'(1);
      if (count_q[class_i] == '0) begin
        dist_q[class_i] <= dist_i;
`ifdef KNN_NEAREST_TIEBREAK_EN
        rank_q[class_i] <= rank_i;
`endif
      end
    end
  end

  assign count_o = count_q;
  assign dist_o  = dist_q;
`ifdef KNN_NEAREST_TIEBREAK_EN
  assign rank_o  = rank_q;
`endif

endmodule

// File: rtl/knn_vote.sv
// KNN majority-vote classifier. Captures the K nearest entries of the sorted
// neighbour bus, counts votes one entry per cycle, scans the classes for the
// winner and pulses valid_class_o with the registered result.
// Optional build macro: KNN_NEAREST_TIEBREAK_EN (equal vote counts resolved in
// favour of the class seen nearest; otherwise the lower class index wins).
module knn_vote
  import knn_pkg::*;
#(
  parameter int N           = KNN_N,
  parameter int W           = KNN_W,
  parameter int K           = KNN_K,
  parameter int NUM_CLASSES = KNN_NUM_CLASSES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_sort_i,
  input  logic [W-1:0] distance_array_sorted_i [0:N-1],
  input  logic [W-1:0] type_array_sorted_i     [0:N-1],
  output logic         ready_o,
  output logic [W-1:0] class_out_o,
  output logic [W-1:0] vote_count_o,
  output logic [W-1:0] winner_distance_o,
  output logic         valid_class_o,
  output logic         overrun_o
);

  localparam int CNT_W  = $clog2(K + 1);
  localparam int RANK_W = (K > 1) ? $clog2(K) : 1;
  localparam int CLS_W  = $clog2(NUM_CLASSES);
  localparam int SCAN_W = $clog2(NUM_CLASSES + 1);

  state_t            state_q, state_d;
  logic [RANK_W-1:0] idx_q, idx_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [CNT_W-1:0]  bestCount_q, bestCount_d;
  logic [CLS_W-1:0]  bestClass_q, bestClass_d;
  logic [W-1:0]      bestDist_q, bestDist_d;
`ifdef KNN_NEAREST_TIEBREAK_EN
  logic [RANK_W-1:0] bestRank_q, bestRank_d;
  logic [RANK_W-1:0] firstRank [NUM_CLASSES];
`endif
  logic [W-1:0]      classOut_q, classOut_d;
  logic [W-1:0]      voteCount_q, voteCount_d;
  logic [W-1:0]      winnerDist_q, winnerDist_d;
  logic              validClass_q, validClass_d;
  logic              overrun_q, overrun_d;

  logic [W-1:0]      typeCap_q [K];
  logic [W-1:0]      distCap_q [K];

  logic [CNT_W-1:0]  counts    [NUM_CLASSES];
  logic [W-1:0]      firstDist [NUM_CLASSES];
  logic              bankClear;
  logic              bankInc;
  logic              take;
  logic [W-1:0]      curType;
  logic              curValid;
  logic [CLS_W-1:0]  scanClass;

  assign curType   = typeCap_q[idx_q];
  assign curValid  = class_valid(64'(curType), NUM_CLASSES);
  assign scanClass = scan_q[CLS_W-1:0];

  knn_class_counters #(
    .NUM_CLASSES(NUM_CLASSES),
    .W          (W),
    .CNT_W      (CNT_W),
    .RANK_W     (RANK_W),
    .CLS_W      (CLS_W)
  ) u_counters (
    .clk     (clk),
    .rst     (rst),
    .clear_i (bankClear),
    .inc_i   (bankInc),
    .class_i (curType[CLS_W-1:0]),
    .dist_i  (distCap_q[idx_q]),
`ifdef KNN_NEAREST_TIEBREAK_EN
    .rank_i  (idx_q),
    .rank_o  (firstRank),
`endif
    .count_o (counts),
    .dist_o  (firstDist)
  );

  // Snapshot the K nearest entries when a new sorted set is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < K; k++) begin
        typeCap_q[k] <= '0;
        distCap_q[k] <= '0;
      end
    end else if (state_q == IDLE && valid_sort_i) begin
      for (int k = 0; k < K; k++) begin
        typeCap_q[k] <= type_array_sorted_i[k];
        distCap_q[k] <= distance_array_sorted_i[k];
      end
    end
  end

  // Controller: accept, count K entries, scan NUM_CLASSES classes, then spend
  // one final ARGMAX cycle registering the winner and pulsing valid.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    scan_d       = scan_q;
    bestCount_d  = bestCount_q;
    bestClass_d  = bestClass_q;
    bestDist_d   = bestDist_q;
`ifdef KNN_NEAREST_TIEBREAK_EN
    bestRank_d   = bestRank_q;
`endif
    classOut_d   = classOut_q;
    voteCount_d  = voteCount_q;
    winnerDist_d = winnerDist_q;
    validClass_d = 1'b0;
    overrun_d    = valid_sort_i && (state_q != IDLE);
    bankClear    = 1'b0;
    bankInc      = 1'b0;
    take         = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_sort_i) begin
          bankClear = 1'b1;
          idx_d     = '0;
          state_d   = COUNT;
        end
      end

      COUNT: begin
        bankInc = curValid;
        idx_d   = idx_q + RANK_W'(1);
        if (idx_q == RANK_W'(K - 1)) begin
          state_d     = ARGMAX;
          scan_d      = '0;
          bestCount_d = '0;
          bestClass_d = '0;
          bestDist_d  = '0;
`ifdef KNN_NEAREST_TIEBREAK_EN
          bestRank_d  = '0;
`endif
        end
      end

      ARGMAX: begin
        if (scan_q != SCAN_W'(NUM_CLASSES)) begin
          take = counts[scanClass] > bestCount_q;
`ifdef KNN_NEAREST_TIEBREAK_EN
          if ((counts[scanClass] == bestCount_q) && (counts[scanClass] != '0) &&
              (firstRank[scanClass] < bestRank_q)) begin
            take = 1'b1;
          end
`endif
          if (take) begin
            bestCount_d = counts[scanClass];
            bestClass_d = scanClass;
            bestDist_d  = firstDist[scanClass];
`ifdef KNN_NEAREST_TIEBREAK_EN
            bestRank_d  = firstRank[scanClass];
`endif
          end
          scan_d = scan_q + SCAN_W'(1);
        end else begin
          classOut_d   = W'(bestClass_q);
          voteCount_d  = W'(bestCount_q);
          winnerDist_d = bestDist_q;
          validClass_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Controller, scan and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      scan_q       <= '0;
      bestCount_q  <= '0;
      bestClass_q  <= '0;
      bestDist_q   <= '0;
`ifdef KNN_NEAREST_TIEBREAK_EN
      bestRank_q   <= '0;
`endif
      classOut_q   <= '0;
      voteCount_q  <= '0;
      winnerDist_q <= '0;
      validClass_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      scan_q       <= scan_d;
      bestCount_q  <= bestCount_d;
      bestClass_q  <= bestClass_d;
      bestDist_q   <= bestDist_d;
`ifdef KNN_NEAREST_TIEBREAK_EN
      bestRank_q   <= bestRank_d;
`endif
      classOut_q   <= classOut_d;
      voteCount_q  <= voteCount_d;
      winnerDist_q <= winnerDist_d;
      validClass_q <= validClass_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ready_o           = (state_q == IDLE);
  assign class_out_o       = classOut_q;
  assign vote_count_o      = voteCount_q;
  assign winner_distance_o = winnerDist_q;
  assign valid_class_o     = validClass_q;
  assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_knn_vote.sv
// Self-checking bench for knn_vote: directed cases plus randomized sorted
// sets checked against a vote-tally reference model.
module tb_knn_vote;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int K  = 3;
  localparam int NC = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_sort;
  logic [W-1:0] distArr [0:N-1];
  logic [W-1:0] typeArr [0:N-1];
  logic         ready;
  logic [W-1:0] classOut;
  logic [W-1:0] voteCount;
  logic [W-1:0] winnerDist;
  logic         validClass;
  logic         overrun;

  logic [W-1:0] stimTypes [0:N-1];
  logic [W-1:0] stimDists [0:N-1];
  int expClass;
  int expCount;
  int expDist;

  int checkCount = 0;
  int passCount  = 0;

  knn_vote #(.N(N), .W(W), .K(K), .NUM_CLASSES(NC)) dut (
    .clk                     (clk),
    .rst                     (rst),
    .valid_sort_i            (valid_sort),
    .distance_array_sorted_i (distArr),
    .type_array_sorted_i     (typeArr),
    .ready_o                 (ready),
    .class_out_o             (classOut),
    .vote_count_o            (voteCount),
    .winner_distance_o       (winnerDist),
    .valid_class_o           (validClass),
    .overrun_o               (overrun)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0d, expected %0d", tag, actual, expected);
  endtask

  // Reference: tally labels of the K nearest entries, pick the largest tally.
  task automatic computeExpected();
    int counts [NC];
    bit done;
    for (int c = 0; c < NC; c++) counts[c] = 0;
    for (int i = 0; i < K; i++)
      if (stimTypes[i] < NC) counts[stimTypes[i]]++;
    expCount = 0;
    expClass = 0;
    for (int c = 0; c < NC; c++)
      if (counts[c] > expCount) begin
        expCount = counts[c];
        expClass = c;
      end
`ifdef KNN_NEAREST_TIEBREAK_EN
    done = 1'b0;
    if (expCount > 0)
      for (int i = 0; i < K; i++)
        if (!done && stimTypes[i] < NC && counts[stimTypes[i]] == expCount) begin
          expClass = int'(stimTypes[i]);
          done = 1'b1;
        end
`endif
    done = 1'b0;
    expDist = 0;
    if (expCount > 0)
      for (int i = 0; i < K; i++)
        if (!done && stimTypes[i] == W'(expClass)) begin
          expDist = int'(stimDists[i]);
          done = 1'b1;
        end
  endtask

  task automatic setStim3(input int t0, input int t1, input int t2,
                          input int d0, input int d1, input int d2);
    stimTypes[0] = W'(t0); stimTypes[1] = W'(t1); stimTypes[2] = W'(t2);
    stimDists[0] = W'(d0); stimDists[1] = W'(d1); stimDists[2] = W'(d2);
    for (int i = 3; i < N; i++) begin
      stimTypes[i] = '0;
      stimDists[i] = W'(d2 + 10 * i);
    end
  endtask

  // Present the stimulus arrays for one clock with valid_sort high.
  task automatic applyStimulus();
    for (int i = 0; i < N; i++) begin
      typeArr[i] = stimTypes[i];
      distArr[i] = stimDists[i];
    end
    valid_sort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_sort = 1'b0;
  endtask

  // Wait (bounded) for valid_class and compare latency and result fields.
  task automatic waitResult(input string tag, input int expLat);
    int cycles = 0;
    bit seen = 1'b0;
    while (!seen && cycles < 24) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (validClass) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, cycles, expLat);
    checkOutput({tag, "_class"}, classOut, expClass);
    checkOutput({tag, "_votes"}, voteCount, expCount);
    checkOutput({tag, "_dist"}, winnerDist, expDist);
    checkOutput({tag, "_ready"}, ready, 1);
  endtask

  task automatic runOne(input string tag);
    computeExpected();
    applyStimulus();
    waitResult(tag, 8);
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_pulse"}, validClass, 0);
  endtask

  initial begin
    bit sawValid;
    int d;
    rst = 1'b1;
    valid_sort = 1'b0;
    for (int i = 0; i < N; i++) begin
      typeArr[i] = '0;
      distArr[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ready", ready, 1);
    checkOutput("rst_class", classOut, 0);
    checkOutput("rst_votes", voteCount, 0);
    checkOutput("rst_dist", winnerDist, 0);
    checkOutput("rst_valid", validClass, 0);
    checkOutput("rst_overrun", overrun, 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);

    setStim3(2, 2, 1, 3, 5, 9);  runOne("basic");
    setStim3(1, 3, 0, 4, 6, 7);  runOne("tie");
    setStim3(5, 5, 2, 1, 2, 3);  runOne("invalid_some");
    setStim3(7, 7, 7, 2, 4, 6);  runOne("invalid_all");

    // A second valid_sort while busy is dropped and flagged.
    setStim3(3, 3, 1, 2, 4, 8);
    computeExpected();
    applyStimulus();
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      typeArr[i] = '0;
      distArr[i] = W'(i);
    end
    valid_sort = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_sort = 1'b0;
    checkOutput("ovr_flag", overrun, 1);
    checkOutput("ovr_busy", ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ovr_flag_drop", overrun, 0);
    waitResult("ovr", 5);
    @(posedge clk);
    @(negedge clk);

    // Reset during COUNT aborts the vote and clears the held result.
    setStim3(2, 1, 2, 5, 6, 7);
    applyStimulus();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_ready", ready, 1);
    checkOutput("midrst_class", classOut, 0);
    checkOutput("midrst_votes", voteCount, 0);
    checkOutput("midrst_dist", winnerDist, 0);
    checkOutput("midrst_valid", validClass, 0);
    sawValid = 1'b0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (validClass) sawValid = 1'b1;
    end
    checkOutput("midrst_no_result", sawValid, 0);
    setStim3(0, 1, 1, 3, 4, 11);  runOne("postrst");

    // New set offered in the very cycle the previous result is valid.
    setStim3(1, 1, 1, 2, 3, 4);
    computeExpected();
    applyStimulus();
    waitResult("b2bA", 8);
    setStim3(3, 0, 3, 6, 9, 12);
    computeExpected();
    applyStimulus();
    checkOutput("b2b_no_overrun", overrun, 0);
    waitResult("b2bB", 8);
    @(posedge clk);
    @(negedge clk);

    for (int n = 0; n < 24; n++) begin
      d = 0;
      for (int i = 0; i < N; i++) begin
        d += $urandom_range(0, 20);
        stimDists[i] = W'(d);
        stimTypes[i] = W'($urandom_range(0, 6));
      end
      runOne($sformatf("rand%0d", n));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
